// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial two's-complement subtractor, d = a - b, LSB first.
//            One full-subtractor cell plus a registered borrow; one operand
//            bit is consumed per clock, so an operation takes WIDTH cycles
//            in SHIFT followed by a single DONE cycle.
// Ports    : clk   - rising-edge clock
//            rst   - asynchronous active-high reset
//            start - request, sampled only while busy=0 (IDLE or DONE)
//            a, b  - minuend / subtrahend, captured on an accepted start
//            d     - registered difference (a - b) mod 2^WIDTH
//            bout  - registered final borrow (1 when a < b unsigned)
//            busy  - high while bits are being processed
//            done  - one-cycle pulse while d/bout carry a fresh result
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] r_ra;
   logic [WIDTH-1:0] r_rb;
   logic [WIDTH-1:0] r_rs;
   logic             r_brw;
   logic [CNT_W-1:0] r_cnt;

   logic             w_diff;
   logic             w_brw_nxt;
   logic             w_accept;
   logic             w_last;

   // Full-subtractor cell on the current LSBs.
   assign w_diff    = r_ra[0] ^ r_rb[0] ^ r_brw;
   assign w_brw_nxt = (~r_ra[0] & r_rb[0]) | (~(r_ra[0] ^ r_rb[0]) & r_brw);

   // A start is honoured in DONE as well as IDLE, which gives back-to-back
   // operations with no idle cycle in between.
   assign w_accept  = start && (r_state != S_SHIFT);
   assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

   assign busy = (r_state == S_SHIFT);
   assign done = (r_state == S_DONE);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = start ? S_SHIFT : S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath: operand shifters, result shifter, borrow, bit counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ra  <= '0;
         r_rb  <= '0;
         r_rs  <= '0;
         r_brw <= 1'b0;
         r_cnt <= '0;
         d     <= '0;
         bout  <= 1'b0;
      end else if (w_accept) begin
         r_ra  <= a;
         r_rb  <= b;
         r_brw <= 1'b0;
         r_cnt <= '0;
      end else if (r_state == S_SHIFT) begin
         r_ra  <= r_ra >> 1;
         r_rb  <= r_rb >> 1;
         r_rs  <= {w_diff, r_rs[WIDTH-1:1]};
         r_brw <= w_brw_nxt;
         // Hold on the last bit so the counter never wraps within an
         // operation; the next accepted start clears it.
         if (!w_last) begin
            r_cnt <= r_cnt + 1'b1;
         end
         // Publish the result on the transition into DONE, taking the
         // final bit and borrow straight from the cell.
         if (w_last) begin
            d    <= {w_diff, r_rs[WIDTH-1:1]};
            bout <= w_brw_nxt;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor at WIDTH=4 and 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst;
   logic       start4, start8;
   logic [3:0] a4, b4, d4;
   logic       bout4, busy4, done4;
   logic [7:0] a8, b8, d8;
   logic       bout8, busy8, done8;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(4)) u_dut4 (
      .clk   (clk),
      .rst   (rst),
      .start (start4),
      .a     (a4),
      .b     (b4),
      .d     (d4),
      .bout  (bout4),
      .busy  (busy4),
      .done  (done4)
   );

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .d     (d8),
      .bout  (bout8),
      .busy  (busy8),
      .done  (done8)
   );

   // One WIDTH=4 operation with full cycle-by-cycle checks.
   task automatic op4(input logic [3:0] ia, input logic [3:0] ib,
                      input logic [3:0] ed, input logic eb, input string name);
      @(negedge clk);
      n_checks++;
      if ({busy4, done4} !== 2'b00) begin
         n_errors++;
         $display("FAIL %s idle: busy,done=%b expected 00", name, {busy4, done4});
      end
      start4 = 1'b1; a4 = ia; b4 = ib;
      @(posedge clk);
      #1;
      start4 = 1'b0; a4 = ~ia; b4 = ~ib;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_checks++;
         if ({busy4, done4} !== 2'b10) begin
            n_errors++;
            $display("FAIL %s busy[%0d]: busy,done=%b expected 10", name, k, {busy4, done4});
         end
      end
      @(negedge clk);
      n_checks++;
      if ({busy4, done4, d4, bout4} !== {2'b01, ed, eb}) begin
         n_errors++;
         $display("FAIL %s result: busy,done=%b d=%h bout=%b expected done d=%h bout=%b",
                  name, {busy4, done4}, d4, bout4, ed, eb);
      end
      @(negedge clk);
      n_checks++;
      if (done4 !== 1'b0) begin
         n_errors++;
         $display("FAIL %s done width: done=%b expected 0", name, done4);
      end
   endtask

   // One WIDTH=8 operation; same structure.
   task automatic op8(input logic [7:0] ia, input logic [7:0] ib,
                      input logic [7:0] ed, input logic eb, input string name);
      @(negedge clk);
      start8 = 1'b1; a8 = ia; b8 = ib;
      @(posedge clk);
      #1;
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         n_checks++;
         if ({busy8, done8} !== 2'b10) begin
            n_errors++;
            $display("FAIL %s busy[%0d]: busy,done=%b expected 10", name, k, {busy8, done8});
         end
      end
      @(negedge clk);
      n_checks++;
      if ({busy8, done8, d8, bout8} !== {2'b01, ed, eb}) begin
         n_errors++;
         $display("FAIL %s result a=%h b=%h: busy,done=%b d=%h bout=%b expected d=%h bout=%b",
                  name, ia, ib, {busy8, done8}, d8, bout8, ed, eb);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
      a4 = 4'h0; b4 = 4'h0; a8 = 8'h00; b8 = 8'h00;
      #12;
      n_checks++;
      if ({busy4, done4, d4, bout4} !== 7'b0) begin
         n_errors++;
         $display("FAIL reset4: busy,done,d,bout=%b expected 0", {busy4, done4, d4, bout4});
      end
      n_checks++;
      if ({busy8, done8, d8, bout8} !== 11'b0) begin
         n_errors++;
         $display("FAIL reset8: busy,done,d,bout=%b expected 0", {busy8, done8, d8, bout8});
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      op4(4'd9,  4'd3,  4'd6, 1'b0, "sub_9_3");
      op4(4'd3,  4'd9,  4'hA, 1'b1, "sub_3_9");
      op4(4'd0,  4'd0,  4'h0, 1'b0, "sub_0_0");
      op4(4'd15, 4'd15, 4'h0, 1'b0, "sub_15_15");
   endtask

   // start held high: (9,3) then (3,9) with no idle cycle between them.
   task automatic test_back_to_back();
      @(negedge clk);
      start4 = 1'b1; a4 = 4'd9; b4 = 4'd3;
      @(posedge clk);
      #1;
      a4 = 4'd3; b4 = 4'd9;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_checks++;
         if ({busy4, done4} !== ((k == 4 || k == 9) ? 2'b01 : 2'b10)) begin
            n_errors++;
            $display("FAIL b2b cycle %0d: busy,done=%b", k, {busy4, done4});
         end
         if (k == 4 || k == 9) begin
            n_checks++;
            if ({d4, bout4} !== ((k == 4) ? {4'd6, 1'b0} : {4'hA, 1'b1})) begin
               n_errors++;
               $display("FAIL b2b result %0d: d=%h bout=%b", k, d4, bout4);
            end
         end else if (k > 4) begin
            n_checks++;
            if ({d4, bout4} !== {4'd6, 1'b0}) begin
               n_errors++;
               $display("FAIL b2b hold %0d: d=%h bout=%b expected d=6 bout=0", k, d4, bout4);
            end
         end
         if (k == 5) start4 = 1'b0;
      end
   endtask

   // start pulsed and operands changed while busy must be ignored.
   task automatic test_ignore_busy();
      int n_done = 0;
      @(negedge clk);
      start4 = 1'b1; a4 = 4'd5; b4 = 4'd7;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done4 === 1'b1) n_done++;
         if (k == 4) begin
            n_checks++;
            if ({done4, d4, bout4} !== {1'b1, 4'hE, 1'b1}) begin
               n_errors++;
               $display("FAIL ignore result: done=%b d=%h bout=%b expected 1 E 1", done4, d4, bout4);
            end
         end
         if (k == 1) begin
            start4 = 1'b1; a4 = 4'd1; b4 = 4'd0;
         end else if (k == 2) begin
            start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
         end
      end
      n_checks++;
      if (n_done != 1) begin
         n_errors++;
         $display("FAIL ignore done count: %0d expected 1", n_done);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      start4 = 1'b1; a4 = 4'd9; b4 = 4'd3;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({busy4, done4, d4, bout4} !== 7'b0) begin
         n_errors++;
         $display("FAIL async reset: busy,done,d,bout=%b expected 0", {busy4, done4, d4, bout4});
      end
      @(negedge clk);
      n_checks++;
      if ({busy4, done4, d4, bout4} !== 7'b0) begin
         n_errors++;
         $display("FAIL reset hold: busy,done,d,bout=%b expected 0", {busy4, done4, d4, bout4});
      end
      // Release and request at once: the first edge must accept the start.
      rst = 1'b0; start4 = 1'b1; a4 = 4'd12; b4 = 4'd5;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_checks++;
         if ({busy4, done4} !== 2'b10) begin
            n_errors++;
            $display("FAIL post-reset busy[%0d]: busy,done=%b expected 10", k, {busy4, done4});
         end
      end
      @(negedge clk);
      n_checks++;
      if ({done4, d4, bout4} !== {1'b1, 4'd7, 1'b0}) begin
         n_errors++;
         $display("FAIL post-reset result: done=%b d=%h bout=%b expected 1 7 0", done4, d4, bout4);
      end
   endtask

   task automatic test_width8();
      logic [7:0] ra, rb;
      op8(8'h00, 8'h01, 8'hFF, 1'b1, "w8_0_1");
      op8(8'h80, 8'h7F, 8'h01, 1'b0, "w8_80_7f");
      op8(8'h10, 8'h20, 8'hF0, 1'b1, "w8_10_20");
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         op8(ra, rb, 8'(ra - rb), (ra < rb), "w8_rand");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_ignore_busy();
      test_async_reset();
      test_width8();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing d = a − b one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the inverse-direction companion of the team's ripple-carry adder and sits in the same arithmetic datapath. It trades latency for area. A start/busy/done handshake lets a controller issue back-to-back operations.

## Interface
- WIDTH, 4, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- d  output  WIDTH  registered difference (a − b) mod 2^WIDTH
- bout  output  1  registered final borrow; 1 when a < b unsigned
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when d/bout are updated

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: busy=0, done=0.
  - On start=1: capture a→ra and b→rb, clear borrow register brw, clear bit counter cnt, go to SHIFT.
- SHIFT: busy=1. Each cycle:
  - diff = ra[0] ^ rb[0] ^ brw
  - brw_next = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & brw)
  - ra and rb shift right by 1; internal result shift register rs shifts right with diff inserted at bit WIDTH−1.
  - cnt increments. After the cycle with cnt = WIDTH−1, go to DONE.
- DONE: busy=0, done=1 for exactly one cycle.
  - d ← rs and bout ← brw are loaded on the transition into DONE, so they are valid while done=1.
  - If start=1 in DONE: accepted exactly as in IDLE (capture, go to SHIFT). Otherwise go to IDLE.
- d and bout hold their last result until the next completion. They do not change during SHIFT.
- start while busy=1 is ignored. Operands are not re-sampled mid-operation, and a/b changes during SHIFT have no effect.
- Arithmetic is unsigned modulo 2^WIDTH. The signed-overflow flag is not provided.
- cnt is ⌈log2(WIDTH)⌉ bits wide. It never wraps past WIDTH−1 within an operation.

## Timing
- Reset (asynchronous, effective immediately, any state): state=IDLE, d=0, bout=0, busy=0, done=0, ra=rb=rs=0, brw=0, cnt=0.
- Reset mid-SHIFT: the operation is aborted. No done pulse occurs and d/bout are cleared to 0.
- First clock edge after reset deassertion: a start sampled at that edge is accepted.
- Latency: start sampled at edge E0 → busy=1 from E0 through edge E0+WIDTH → done=1 and d/bout valid in the cycle after edge E0+WIDTH.
- Throughput: start held high continuously gives one result every WIDTH+1 cycles, with done pulses WIDTH+1 cycles apart.
- busy and done are never high simultaneously.

## Test plan
- WIDTH=4, a=9, b=3, start one cycle → busy high 4 cycles, then done pulse with d=6, bout=0.
- WIDTH=4, a=3, b=9 → d=4'hA, bout=1. Also a=0, b=0 → d=0, bout=0. Also a=15, b=15 → d=0, bout=0.
- Back-to-back: start held high with operands (9,3) then (3,9) → done pulses 5 cycles apart, results 6/0 then 10/1, with no idle cycle between operations.
- Start pulsed and a/b changed while busy=1 → ignored. Result matches the originally captured operands, and exactly one done pulse occurs.
- Reset asserted asynchronously mid-SHIFT (between edges) → busy, done, d, bout go to 0 immediately with no done pulse. A new start after deassertion completes normally.
- WIDTH=8, a=8'h00, b=8'h01 → d=8'hFF, bout=1 after 8 busy cycles. Randomized compare against (a − b) mod 256 for 1000 operations.
